uart_cmd_master: RTL and testbench
==================================

Name: uart_cmd_master

Overview:
- Host-side counterpart of the PSRAM UART command port. It runs in a second FPGA or in a bench harness.
- Accepts one read or write request per handshake and serialises it on uart_tx as an ASCII command frame.
  - Write: 'W' (0x57), 3 address bytes, 2 data bytes.
  - Read: 'R' (0x52), 3 address bytes.
- For a read, it then deserialises the 2-byte response (MSB first) on uart_rx and returns it with a done pulse.

Parameters:
- DELAY_FRAMES, 234, clocks per UART bit (27 MHz / 115200).
- TIMEOUT_CYCLES, 1048576, maximum clocks in WAIT_RSP before a read is aborted.

Ports:
- sys_clk  in  1  system clock (27 MHz); all logic on posedge.
- sys_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  request strobe.
- cmd_ready  out  1  high when IDLE; a request is accepted on cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  23  PSRAM word address.
- cmd_data  in  16  write data; ignored for reads.
- done  out  1  one-cycle pulse at command completion.
- rsp_valid  out  1  one-cycle pulse, coincident with done, on a successful read.
- rsp_data  out  16  read data; held until the next read completes.
- rsp_error  out  1  one-cycle pulse with done on read timeout or response framing error.
- busy  out  1  ~cmd_ready.
- uart_tx  out  1  serial out, idle high.
- uart_rx  in  1  serial in, asynchronous; double-flop synchronised.

Behaviour:
- Reset values: uart_tx=1, cmd_ready=1, busy=0, done=0, rsp_valid=0, rsp_error=0, rsp_data=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts at once: uart_tx returns high asynchronously. No partial completion pulse is issued.
- On accept, the request is latched into a 6-byte frame register and the accept-cycle inputs are captured:
  - byte0 = 0x57 or 0x52.
  - byte1 = {1'b0, addr[22:16]}.
  - byte2 = addr[15:8].
  - byte3 = addr[7:0].
  - byte4 = data[15:8].
  - byte5 = data[7:0].
  - Frame length is 6 for a write, 4 for a read.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
  - IDLE -> SEND on accept. cmd_ready drops the cycle after accept.
  - SEND: bytes go out back-to-back with no gap.
    - Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit DELAY_FRAMES clocks, so 10*DELAY_FRAMES per byte.
    - After the last stop bit completes: a write goes to DONE; a read goes to WAIT_RSP.
  - WAIT_RSP:
    - The receiver is enabled and the timeout counter is cleared on entry.
    - 2 bytes are collected; the first byte goes to rsp_data[15:8].
    - When the second stop bit is sampled valid, go to DONE with rsp_valid.
    - When the timeout counter reaches TIMEOUT_CYCLES, go to DONE with rsp_error. rsp_data keeps its previous value.
  - DONE: lasts 1 cycle and pulses done (plus rsp_valid or rsp_error), then returns to IDLE.
- Receiver:
  - Enabled only in WAIT_RSP; bytes arriving in other states are discarded.
  - Start detect is a synchronised low.
  - At DELAY_FRAMES/2 the line is re-checked. If it is high, treat it as a glitch and return to receiver idle (this does not count as an error).
  - Each data bit and the stop bit is then sampled every DELAY_FRAMES clocks.
  - Stop bit sampled 0 is a framing error: go to DONE with rsp_error.
- Latency:
  - Write: accept to done = 6*10*DELAY_FRAMES + 1 clocks (14041 at default).
  - Read: 4*10*DELAY_FRAMES + 1 clocks, plus response time.
- cmd_valid while busy is ignored and never queued.
- Counters are sized by $clog2 of their limit. All comparisons are done at full width with no wrap; each counter saturates or clears at its limit.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - CMD_READ = 8'h52, CMD_WRITE = 8'h57, CMD_RESET = 8'h2F.
  - Frame lengths: WR = 6, RD = 4.
  - The FSM state enum.
  - The address byte-packing function.
- One sub-module, uart_byte_tx (start/data/stop serialiser with a start/done handshake). Instantiate it once and reuse it for each frame byte.
- The receiver stays inline because it is used only in WAIT_RSP.

Test Plan (simulate with DELAY_FRAMES=8, TIMEOUT_CYCLES=2000):
- Write: cmd_address=0x012345, cmd_data=0xBEEF -> uart_tx bytes 0x57,0x01,0x23,0x45,0xBE,0xEF, bit period 8; done exactly 481 clocks after accept; rsp_valid stays 0.
- Read: cmd_address=0x7FFFFF -> tx 0x52,0x7F,0xFF,0xFF; the bench replies 0xA5,0x3C -> rsp_valid and done coincide; rsp_data=0xA53C; rsp_error=0.
- Read with no reply -> done and rsp_error 2000 clocks after WAIT_RSP entry; rsp_data keeps 0xA53C.
- Read reply byte with stop bit 0 -> rsp_error and done; a 2-clock low glitch on uart_rx in WAIT_RSP is ignored and the following valid reply is still captured.
- Assert sys_rst_n=0 during byte 2 of a write -> uart_tx=1 and cmd_ready=1 immediately; no done pulse; the next command transmits correctly.
- Pulse cmd_valid with cmd_write=1 during SEND of a read -> ignored; exactly one 4-byte frame goes out; the following accepted command is unaffected.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and frame packing for the UART command master.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_RESET = 8'h2F;

    localparam logic [2:0] FRAME_LEN_WR = 3'd6;
    localparam logic [2:0] FRAME_LEN_RD = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RSP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Byte 0 (the command letter) lands in bits [47:40] so the frame shifts out MSB-byte first.
    function automatic logic [47:0] pack_frame(input logic       write,
                                               input logic [22:0] addr,
                                               input logic [15:0] data);
        return {(write ? CMD_WRITE : CMD_READ), 1'b0, addr[22:16], addr[15:8], addr[7:0], data};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; a new start is accepted in the same cycle as done for gap-free frames.
module uart_byte_tx #(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int             CW       = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(DELAY_FRAMES - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;

    assign done = busy && (cnt == BIT_LAST) && (bit_idx == 4'd9);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else if (start) begin
            tx      <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, data};
        end else if (busy) begin
            if (cnt == BIT_LAST) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    busy <= 1'b0;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_master.sv
// Serialises read/write requests as ASCII UART command frames and collects 2-byte read responses.
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int DELAY_FRAMES   = 234,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [22:0] cmd_address,
    input  logic [15:0] cmd_data,
    output logic        done,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic        busy,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int             CW        = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
    localparam int             TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [47:0] frame;
    logic [2:0]  frame_len;
    logic [2:0]  byte_idx;
    logic        is_write;
    logic        accept;
    logic        tx_start, tx_busy, tx_done;
    logic        set_ok, set_err;

    rx_state_t   rx_state;
    logic        rx_meta, rx_sync;
    logic [CW-1:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_hi;
    logic        rx_have_first;
    logic        rx_stop_sample, rx_byte_ok, rx_frame_err;
    logic [TW-1:0] to_cnt;
    logic        timeout;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

    uart_byte_tx #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_byte_tx (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .start(tx_start),
        .data (frame[47:40]),
        .tx   (uart_tx),
        .busy (tx_busy),
        .done (tx_done)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        set_ok     = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: if (accept) state_next = SEND;
            SEND: begin
                tx_start = (!tx_busy || tx_done) && (byte_idx != frame_len);
                if (tx_done && (byte_idx == frame_len))
                    state_next = is_write ? DONE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rx_byte_ok && rx_have_first) begin
                    state_next = DONE;
                    set_ok     = 1'b1;
                end else if (rx_frame_err || timeout) begin
                    state_next = DONE;
                    set_err    = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            frame     <= '0;
            frame_len <= '0;
            byte_idx  <= '0;
            is_write  <= 1'b0;
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_next;
            done      <= (state_next == DONE);
            rsp_valid <= set_ok;
            rsp_error <= set_err;
            if (accept) begin
                frame     <= pack_frame(cmd_write, cmd_address, cmd_data);
                frame_len <= cmd_write ? FRAME_LEN_WR : FRAME_LEN_RD;
                is_write  <= cmd_write;
                byte_idx  <= '0;
            end else if (tx_start) begin
                frame    <= {frame[39:0], 8'h00};
                byte_idx <= byte_idx + 3'd1;
            end
            if (set_ok)
                rsp_data <= {rx_hi, rx_shift};
        end
    end

    // uart_rx comes from another clock domain; two flops before any decision is made on it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_stop_sample = (state == WAIT_RSP) && (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    assign rx_byte_ok     = rx_stop_sample && rx_sync;
    assign rx_frame_err   = rx_stop_sample && !rx_sync;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_hi         <= '0;
            rx_have_first <= 1'b0;
        end else if (state != WAIT_RSP) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_have_first <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: if (!rx_sync) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
                RX_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                RX_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    else                rx_bit   <= rx_bit + 3'd1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                RX_STOP: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= RX_IDLE;
                    if (rx_sync && !rx_have_first) begin
                        rx_hi         <= rx_shift;
                        rx_have_first <= 1'b1;
                    end
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign timeout = (state == WAIT_RSP) && (to_cnt == TO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            to_cnt <= '0;
        else if (state != WAIT_RSP)
            to_cnt <= '0;
        else if (to_cnt != TO_LAST)
            to_cnt <= to_cnt + TW'(1);
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master: decoded uart_tx bytes and completion pulses are checked against queued expectations.
module tb_uart_cmd_master;

    localparam int D  = 8;
    localparam int TO = 2000;
    localparam int WR_LAT  = 60 * D + 1;
    localparam int RSP_ENT = 40 * D + 1;

    logic        sys_clk, sys_rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [22:0] cmd_address;
    logic [15:0] cmd_data;
    logic        done, rsp_valid, rsp_error, busy, uart_tx, uart_rx;
    logic [15:0] rsp_data;

    typedef struct {
        logic        valid;
        logic        err;
        logic [15:0] data;
        int          lat;
    } cpl_t;

    logic [7:0] exp_tx[$];
    cpl_t       exp_cpl[$];
    int checks, errors, cyc, accept_cyc, done_count, mark;

    uart_cmd_master #(
        .DELAY_FRAMES  (D),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_address(cmd_address),
        .cmd_data   (cmd_data),
        .done       (done),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_error  (rsp_error),
        .busy       (busy),
        .uart_tx    (uart_tx),
        .uart_rx    (uart_rx)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decodes each uart_tx byte, sampling mid-bit at the nominal D-clock period.
    initial begin : tx_monitor
        forever begin
            logic [9:0] bits;
            bit         ab;
            @(negedge sys_clk);
            if (sys_rst_n === 1'b1 && uart_tx === 1'b0) begin
                ab   = 1'b0;
                bits = '0;
                for (int bi = 0; bi < 10 && !ab; bi++) begin
                    for (int k = 0; k < ((bi == 0) ? D / 2 : D); k++) begin
                        @(negedge sys_clk);
                        if (sys_rst_n !== 1'b1) ab = 1'b1;
                    end
                    if (!ab) bits[bi] = uart_tx;
                end
                if (!ab) begin
                    check("tx start bit", bits[0], 1'b0);
                    check("tx stop bit", bits[9], 1'b1);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx unexpected byte: got 0x%0h expected none", bits[8:1]);
                    end else begin
                        check("tx byte", bits[8:1], exp_tx.pop_front());
                    end
                end
            end
        end
    end

    initial begin : cpl_monitor
        forever begin
            cpl_t e;
            @(negedge sys_clk);
            if (done === 1'b1 || rsp_valid === 1'b1 || rsp_error === 1'b1) begin
                done_count++;
                if (exp_cpl.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected completion: got done=%0b rsp_valid=%0b rsp_error=%0b expected none",
                             done, rsp_valid, rsp_error);
                end else begin
                    e = exp_cpl.pop_front();
                    check("done pulse", done, 1'b1);
                    check("rsp_valid", rsp_valid, e.valid);
                    check("rsp_error", rsp_error, e.err);
                    check("rsp_data", rsp_data, e.data);
                    if (e.lat >= 0) check("completion latency", cyc - accept_cyc, e.lat);
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [22:0] addr, input logic [15:0] data);
        for (int n = 0; n < 5000 && cmd_ready !== 1'b1; n++) @(negedge sys_clk);
        if (cmd_ready !== 1'b1) check("cmd_ready before issue", cmd_ready, 1'b1);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = addr;
        cmd_data    = data;
        @(negedge sys_clk);
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target, input int max_cycles);
        for (int n = 0; n < max_cycles && done_count < target; n++) @(negedge sys_clk);
        if (done_count < target) check(name, done_count, target);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (D) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (D) @(negedge sys_clk);
        end
        uart_rx = stop;
        repeat (D) @(negedge sys_clk);
        uart_rx = 1'b1;
    endtask

    task automatic push_bytes(input logic [47:0] bytes, input int n);
        for (int i = 0; i < n; i++) exp_tx.push_back(bytes[47 - 8 * i -: 8]);
    endtask

    initial begin
        checks = 0; errors = 0; done_count = 0; accept_cyc = 0; mark = 0;
        sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_address = '0; cmd_data = '0; uart_rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset uart_tx", uart_tx, 1'b1);
        check("reset cmd_ready", cmd_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_error", rsp_error, 1'b0);
        check("reset rsp_data", rsp_data, 16'h0000);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Write frame and exact accept-to-done latency.
        push_bytes(48'h57_01_23_45_BE_EF, 6);
        exp_cpl.push_back(cpl_t'{1'b0, 1'b0, 16'h0000, WR_LAT});
        mark = done_count + 1;
        send_cmd(1'b1, 23'h012345, 16'hBEEF);
        check("busy after accept", busy, 1'b1);
        wait_done("write done timeout", mark, 700);
        repeat (5) @(negedge sys_clk);

        // Read with a good two-byte reply.
        push_bytes(48'h52_7F_FF_FF_00_00, 4);
        exp_cpl.push_back(cpl_t'{1'b1, 1'b0, 16'hA53C, -1});
        mark = done_count + 1;
        send_cmd(1'b0, 23'h7FFFFF, 16'h0000);
        repeat (RSP_ENT + 9) @(negedge sys_clk);
        rx_byte(8'hA5, 1'b1);
        rx_byte(8'h3C, 1'b1);
        wait_done("read done timeout", mark, 400);
        repeat (5) @(negedge sys_clk);

        // Read with no reply: timeout exactly TO clocks after WAIT_RSP entry.
        push_bytes(48'h52_2A_AA_AA_00_00, 4);
        exp_cpl.push_back(cpl_t'{1'b0, 1'b1, 16'hA53C, RSP_ENT + TO});
        mark = done_count + 1;
        send_cmd(1'b0, 23'h2AAAAA, 16'h0000);
        wait_done("read timeout done", mark, RSP_ENT + TO + 200);
        repeat (5) @(negedge sys_clk);

        // Reply byte whose stop bit is low.
        push_bytes(48'h52_00_00_10_00_00, 4);
        exp_cpl.push_back(cpl_t'{1'b0, 1'b1, 16'hA53C, -1});
        mark = done_count + 1;
        send_cmd(1'b0, 23'h000010, 16'h0000);
        repeat (RSP_ENT + 9) @(negedge sys_clk);
        rx_byte(8'h11, 1'b0);
        wait_done("framing error done", mark, 400);
        repeat (10) @(negedge sys_clk);

        // A 2-clock low glitch before the reply is ignored.
        push_bytes(48'h52_40_00_01_00_00, 4);
        exp_cpl.push_back(cpl_t'{1'b1, 1'b0, 16'h1234, -1});
        mark = done_count + 1;
        send_cmd(1'b0, 23'h400001, 16'h0000);
        repeat (RSP_ENT + 9) @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge sys_clk);
        rx_byte(8'h12, 1'b1);
        rx_byte(8'h34, 1'b1);
        wait_done("glitch read done", mark, 400);
        repeat (5) @(negedge sys_clk);

        // Reset in the middle of byte 2 of a write.
        push_bytes(48'h57_00_00_00_00_00, 2);
        send_cmd(1'b1, 23'h000ABC, 16'h1234);
        repeat (20 * D + 1 + 30) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("mid-frame reset uart_tx", uart_tx, 1'b1);
        check("mid-frame reset cmd_ready", cmd_ready, 1'b1);
        check("mid-frame reset busy", busy, 1'b0);
        check("bytes before reset", exp_tx.size(), 0);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        push_bytes(48'h57_3F_FF_FF_00_01, 6);
        exp_cpl.push_back(cpl_t'{1'b0, 1'b0, 16'h0000, WR_LAT});
        mark = done_count + 1;
        send_cmd(1'b1, 23'h3FFFFF, 16'h0001);
        wait_done("post-reset write done", mark, 700);
        repeat (5) @(negedge sys_clk);

        // cmd_valid while busy is dropped, not queued.
        push_bytes(48'h52_05_5A_A5_00_00, 4);
        exp_cpl.push_back(cpl_t'{1'b1, 1'b0, 16'hC35A, -1});
        mark = done_count + 1;
        send_cmd(1'b0, 23'h055AA5, 16'h0000);
        repeat (50) @(negedge sys_clk);
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_address = 23'h111111;
        cmd_data    = 16'hFFFF;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        repeat (RSP_ENT + 9 - 51) @(negedge sys_clk);
        rx_byte(8'hC3, 1'b1);
        rx_byte(8'h5A, 1'b1);
        wait_done("busy-ignore read done", mark, 400);
        repeat (20) @(negedge sys_clk);
        check("no extra frame queued", cmd_ready, 1'b1);

        push_bytes(48'h57_00_00_01_00_FF, 6);
        exp_cpl.push_back(cpl_t'{1'b0, 1'b0, 16'hC35A, WR_LAT});
        mark = done_count + 1;
        send_cmd(1'b1, 23'h000001, 16'h00FF);
        wait_done("final write done", mark, 700);

        repeat (100) @(negedge sys_clk);
        check("tx bytes outstanding", exp_tx.size(), 0);
        check("completions outstanding", exp_cpl.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
